// File: rtl/link_arbiter.sv
// link_arbiter: round-robin sharing of one link between several output buffers.
// Per-flit arbitration, registered flit/valid mux, credit return routing,
// transmitted-flit counter and a sticky protocol-error flag.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module link_arbiter #(
    parameter int N_OUT_BUFFERS     = 4,
    parameter int N_BITS_VC_ID      = 3,
    parameter int N_BITS_FLIT_COUNT = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_OUT_BUFFERS-1:0]              r_la_i,
    output logic [N_OUT_BUFFERS-1:0]              g_la_o,
    input  logic [N_OUT_BUFFERS*`FLIT_WIDTH-1:0]  flit_i,
    input  logic [N_OUT_BUFFERS-1:0]              is_valid_i,
    output logic [`FLIT_WIDTH-1:0]                flit_o,
    output logic                                  is_valid_o,
    input  logic                                  credit_in_i,
    input  logic [N_BITS_VC_ID-1:0]               credit_vc_id_i,
    input  logic [N_OUT_BUFFERS*N_BITS_VC_ID-1:0] vc_id_i,
    input  logic [N_OUT_BUFFERS-1:0]              busy_i,
    output logic [N_OUT_BUFFERS-1:0]              credit_o,
    output logic [N_BITS_FLIT_COUNT-1:0]          flit_count_o,
    output logic                                  error_o
);

    localparam int FW = `FLIT_WIDTH;
    localparam int PW = (N_OUT_BUFFERS > 1) ? $clog2(N_OUT_BUFFERS) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_OUT_BUFFERS - 1);
    localparam logic [N_BITS_FLIT_COUNT-1:0] COUNT_ONE = {{(N_BITS_FLIT_COUNT-1){1'b0}}, 1'b1};

    logic [PW-1:0]            prio_r;
    logic [PW-1:0]            prio_next;
    logic [N_OUT_BUFFERS-1:0] grant;
    logic                     grant_any;
    logic [PW-1:0]            win_idx;
    logic [FW-1:0]            sel_flit;
    logic [N_OUT_BUFFERS-1:0] match;
    logic [N_OUT_BUFFERS-1:0] credit_next;
    logic                     multi_valid;
    logic                     multi_match;

    // Rotating-priority search: first requester at or after prio_r, wrapping.
    always_comb begin
        int idx;
        grant     = '0;
        grant_any = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < N_OUT_BUFFERS; i++) begin
            idx = (int'(prio_r) + i) % N_OUT_BUFFERS;
            if (!grant_any && r_la_i[idx]) begin
                grant[idx] = 1'b1;
                grant_any  = 1'b1;
                win_idx    = PW'(idx);
            end
        end
    end

    // Winner's successor becomes the new highest-priority index.
    always_comb begin
        prio_next = prio_r;
        if (grant_any) begin
            prio_next = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
        end
    end

    // Grant is suppressed during reset so no buffer starts a transfer.
    assign g_la_o = rst ? '0 : grant;

    // Flit mux: the lowest valid buffer wins if several collide.
    always_comb begin
        sel_flit = flit_i[FW-1:0];
        for (int i = N_OUT_BUFFERS - 1; i >= 0; i--) begin
            if (is_valid_i[i]) begin
                sel_flit = flit_i[i*FW +: FW];
            end
        end
    end

    // A credit matches a buffer that is occupied and owns the credit's VC.
    generate
        for (genvar gi = 0; gi < N_OUT_BUFFERS; gi++) begin : g_match
            assign match[gi] = credit_in_i & busy_i[gi] &
                               (vc_id_i[gi*N_BITS_VC_ID +: N_BITS_VC_ID] == credit_vc_id_i);
        end
    endgenerate

    // Route the credit to the lowest matching buffer only; no match drops it.
    always_comb begin
        credit_next = '0;
        for (int i = N_OUT_BUFFERS - 1; i >= 0; i--) begin
            if (match[i]) begin
                credit_next    = '0;
                credit_next[i] = 1'b1;
            end
        end
    end

    assign multi_valid = ($countones(is_valid_i) > 1);
    assign multi_match = ($countones(match) > 1);

    // Priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= '0;
        end else begin
            prio_r <= prio_next;
        end
    end

    // Registered link output; flit holds when nothing is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_o     <= '0;
            is_valid_o <= 1'b0;
        end else begin
            is_valid_o <= |is_valid_i;
            if (|is_valid_i) begin
                flit_o <= sel_flit;
            end
        end
    end

    // Transmitted-flit counter, counts alongside is_valid_o and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_count_o <= '0;
        end else if (|is_valid_i) begin
            flit_count_o <= flit_count_o + COUNT_ONE;
        end
    end

    // One-cycle credit pulse toward the owning buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_o <= '0;
        end else begin
            credit_o <= credit_next;
        end
    end

    // Sticky error on valid collision or ambiguous credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_o <= 1'b0;
        end else if (multi_valid || multi_match) begin
            error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module tb_link_arbiter;

    localparam int N  = 4;
    localparam int VW = 3;
    localparam int FW = `FLIT_WIDTH;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      r_la_i;
    logic [N-1:0]      g_la_o;
    logic [N*FW-1:0]   flit_i;
    logic [N-1:0]      is_valid_i;
    logic [FW-1:0]     flit_o;
    logic              is_valid_o;
    logic              credit_in_i;
    logic [VW-1:0]     credit_vc_id_i;
    logic [N*VW-1:0]   vc_id_i;
    logic [N-1:0]      busy_i;
    logic [N-1:0]      credit_o;
    logic [CW-1:0]     flit_count_o;
    logic              error_o;

    // Small-counter instance for the wrap scenario.
    logic [N-1:0]      g4;
    logic [FW-1:0]     flit4;
    logic              valid4;
    logic [N-1:0]      credit4;
    logic [3:0]        count4;
    logic              err4;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int           m_prio;
    logic [FW-1:0] m_flit;
    logic         m_valid;
    logic [N-1:0] m_credit;
    logic [CW-1:0] m_count;
    logic         m_err;

    always #5 clk = ~clk;

    link_arbiter #(.N_OUT_BUFFERS(N), .N_BITS_VC_ID(VW), .N_BITS_FLIT_COUNT(CW)) dut (
        .clk(clk), .rst(rst), .r_la_i(r_la_i), .g_la_o(g_la_o), .flit_i(flit_i),
        .is_valid_i(is_valid_i), .flit_o(flit_o), .is_valid_o(is_valid_o),
        .credit_in_i(credit_in_i), .credit_vc_id_i(credit_vc_id_i), .vc_id_i(vc_id_i),
        .busy_i(busy_i), .credit_o(credit_o), .flit_count_o(flit_count_o), .error_o(error_o)
    );

    link_arbiter #(.N_OUT_BUFFERS(N), .N_BITS_VC_ID(VW), .N_BITS_FLIT_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .r_la_i(r_la_i), .g_la_o(g4), .flit_i(flit_i),
        .is_valid_i(is_valid_i), .flit_o(flit4), .is_valid_o(valid4),
        .credit_in_i(credit_in_i), .credit_vc_id_i(credit_vc_id_i), .vc_id_i(vc_id_i),
        .busy_i(busy_i), .credit_o(credit4), .flit_count_o(count4), .error_o(err4)
    );

    // Winner index by the rotating-priority rule, -1 when nobody requests.
    function automatic int model_winner(logic [N-1:0] req, int prio);
        for (int i = 0; i < N; i++) begin
            if (req[(prio + i) % N]) return (prio + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_grant(logic [N-1:0] req, int prio);
        logic [N-1:0] g;
        int w;
        g = '0;
        w = model_winner(req, prio);
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_prio   = 0;
        m_flit   = '0;
        m_valid  = 1'b0;
        m_credit = '0;
        m_count  = '0;
        m_err    = 1'b0;
    endtask

    task automatic idle_inputs();
        r_la_i         = '0;
        flit_i         = '0;
        is_valid_i     = '0;
        credit_in_i    = 1'b0;
        credit_vc_id_i = '0;
        vc_id_i        = '0;
        busy_i         = '0;
    endtask

    // Advance one rising edge, update the model from the inputs seen at that edge.
    task automatic tick();
        int w;
        int nv;
        int lo;
        int nm;
        int lm;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            w = model_winner(r_la_i, m_prio);
            if (w >= 0) m_prio = (w + 1) % N;
            nv = 0; lo = -1; nm = 0; lm = -1;
            for (int j = 0; j < N; j++) begin
                if (is_valid_i[j]) begin
                    nv++;
                    if (lo < 0) lo = j;
                end
                if (credit_in_i && busy_i[j] && vc_id_i[j*VW +: VW] == credit_vc_id_i) begin
                    nm++;
                    if (lm < 0) lm = j;
                end
            end
            m_valid = (nv > 0);
            if (nv > 0) begin
                m_flit  = flit_i[lo*FW +: FW];
                m_count = m_count + 16'd1;
            end
            m_credit = '0;
            if (lm >= 0) m_credit[lm] = 1'b1;
            if (nv > 1 || nm > 1) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        r_la_i = 4'b1111;
        tick();
        tick();
        tests_run++; if (g_la_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got=%b want=0000", g_la_o); end
        tests_run++; if (flit_o !== '0) begin tests_failed++; $display("FAIL reset_flit got=%h want=0", flit_o); end
        tests_run++; if (is_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b want=0", is_valid_o); end
        tests_run++; if (credit_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_credit got=%b want=0000", credit_o); end
        tests_run++; if (flit_count_o !== '0) begin tests_failed++; $display("FAIL reset_count got=%0d want=0", flit_count_o); end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL reset_error got=%b want=0", error_o); end
        rst = 1'b0;
        idle_inputs();
        $display("[TB] reset: outputs checked while rst high");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] expv;
        r_la_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #2;
            expv = '0;
            expv[c % N] = 1'b1;
            tests_run++;
            if (g_la_o !== expv) begin
                tests_failed++;
                $display("FAIL round_robin cycle=%0d got=%b want=%b", c, g_la_o, expv);
            end
            $display("[TB] round_robin cycle=%0d grant=%b", c, g_la_o);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        logic [CW-1:0] c0;
        c0 = flit_count_o;
        r_la_i = 4'b0100;
        #2;
        tests_run++; if (g_la_o !== 4'b0100) begin tests_failed++; $display("FAIL latency_grant got=%b want=0100", g_la_o); end
        tick();
        r_la_i = '0;
        is_valid_i = 4'b0100;
        flit_i = '0;
        flit_i[2*FW +: FW] = FW'(32'hA5A5_1234);
        tick();
        is_valid_i = '0;
        tests_run++; if (is_valid_o !== 1'b1) begin tests_failed++; $display("FAIL latency_valid got=%b want=1", is_valid_o); end
        tests_run++; if (flit_o !== FW'(32'hA5A5_1234)) begin tests_failed++; $display("FAIL latency_flit got=%h want=%h", flit_o, FW'(32'hA5A5_1234)); end
        tests_run++; if (flit_count_o !== c0 + 16'd1) begin tests_failed++; $display("FAIL latency_count got=%0d want=%0d", flit_count_o, c0 + 16'd1); end
        tick();
        tests_run++; if (is_valid_o !== 1'b0) begin tests_failed++; $display("FAIL latency_valid_drop got=%b want=0", is_valid_o); end
        tests_run++; if (flit_o !== FW'(32'hA5A5_1234)) begin tests_failed++; $display("FAIL latency_flit_hold got=%h want=%h", flit_o, FW'(32'hA5A5_1234)); end
        $display("[TB] latency: flit=%h count=%0d", flit_o, flit_count_o);
        idle_inputs();
    endtask

    task automatic test_credit();
        busy_i = 4'b0110;
        vc_id_i = {3'b100, 3'b100, 3'b010, 3'b100};
        credit_in_i = 1'b1;
        credit_vc_id_i = 3'b100;
        tick();
        credit_in_i = 1'b0;
        tests_run++; if (credit_o !== 4'b0100) begin tests_failed++; $display("FAIL credit_route got=%b want=0100", credit_o); end
        tick();
        tests_run++; if (credit_o !== 4'b0000) begin tests_failed++; $display("FAIL credit_pulse got=%b want=0000", credit_o); end
        busy_i = 4'b0010;
        credit_in_i = 1'b1;
        tick();
        credit_in_i = 1'b0;
        tests_run++; if (credit_o !== 4'b0000) begin tests_failed++; $display("FAIL credit_drop got=%b want=0000", credit_o); end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL credit_no_error got=%b want=0", error_o); end
        $display("[TB] credit: routing and drop checked");
        idle_inputs();
    endtask

    task automatic test_collision();
        logic [FW-1:0] f0;
        f0 = FW'($urandom);
        flit_i = '0;
        flit_i[0 +: FW] = f0;
        flit_i[FW +: FW] = ~f0;
        is_valid_i = 4'b0011;
        tick();
        idle_inputs();
        tests_run++; if (error_o !== 1'b1) begin tests_failed++; $display("FAIL collision_error got=%b want=1", error_o); end
        tests_run++; if (flit_o !== f0) begin tests_failed++; $display("FAIL collision_flit got=%h want=%h", flit_o, f0); end
        for (int c = 0; c < 10; c++) tick();
        tests_run++; if (error_o !== 1'b1) begin tests_failed++; $display("FAIL collision_sticky got=%b want=1", error_o); end
        tests_run++; if (flit_o !== f0) begin tests_failed++; $display("FAIL collision_hold got=%h want=%h", flit_o, f0); end
        $display("[TB] collision: error=%b flit=%h", error_o, flit_o);
    endtask

    task automatic test_reset_mid();
        r_la_i = 4'b0010;
        is_valid_i = 4'b0001;
        flit_i = '0;
        flit_i[0 +: FW] = FW'(32'hDEAD_BEEF);
        busy_i = 4'b0001;
        vc_id_i = '0;
        vc_id_i[0 +: VW] = 3'b001;
        credit_in_i = 1'b1;
        credit_vc_id_i = 3'b001;
        tick();
        tests_run++; if (is_valid_o !== 1'b1 || credit_o !== 4'b0001) begin tests_failed++; $display("FAIL midreset_setup valid=%b credit=%b want=1,0001", is_valid_o, credit_o); end
        r_la_i = 4'b1111;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (g_la_o !== '0 || flit_o !== '0 || is_valid_o !== 1'b0 || credit_o !== '0 || flit_count_o !== '0 || error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_zero g=%b f=%h v=%b c=%b n=%0d e=%b want all 0", g_la_o, flit_o, is_valid_o, credit_o, flit_count_o, error_o);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        r_la_i = 4'b1111;
        #2;
        tests_run++; if (g_la_o !== 4'b0001) begin tests_failed++; $display("FAIL midreset_first_grant got=%b want=0001", g_la_o); end
        tick();
        idle_inputs();
        $display("[TB] reset_mid: restart grant checked");
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        model_reset();
        idle_inputs();
        tick();
        rst = 1'b0;
        is_valid_i = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            flit_i[0 +: FW] = FW'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        tests_run++; if (count4 !== 4'd1) begin tests_failed++; $display("FAIL wrap_count4 got=%0d want=1", count4); end
        tests_run++; if (flit_count_o !== 16'd17) begin tests_failed++; $display("FAIL wrap_count16 got=%0d want=17", flit_count_o); end
        $display("[TB] wrap: count4=%0d count16=%0d", count4, flit_count_o);
    endtask

    task automatic test_random();
        logic [N-1:0] expg;
        logic [VW-1:0] vc;
        rst = 1'b1;
        model_reset();
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            r_la_i = N'($urandom);
            for (int j = 0; j < N; j++) begin
                flit_i[j*FW +: FW] = FW'($urandom);
                vc = '0;
                vc[$urandom_range(VW-1, 0)] = 1'b1;
                vc_id_i[j*VW +: VW] = vc;
            end
            if ($urandom_range(99, 0) < 3) is_valid_i = N'($urandom);
            else if ($urandom_range(1, 0) == 1) begin
                is_valid_i = '0;
                is_valid_i[$urandom_range(N-1, 0)] = 1'b1;
            end else is_valid_i = '0;
            busy_i = N'($urandom);
            credit_in_i = ($urandom_range(1, 0) == 1);
            vc = '0;
            vc[$urandom_range(VW-1, 0)] = 1'b1;
            credit_vc_id_i = vc;
            #2;
            expg = model_grant(r_la_i, m_prio);
            tests_run++; if (g_la_o !== expg) begin tests_failed++; $display("FAIL rand_grant cycle=%0d got=%b want=%b", c, g_la_o, expg); end
            tick();
            tests_run++;
            if (is_valid_o !== m_valid || flit_o !== m_flit || credit_o !== m_credit ||
                flit_count_o !== m_count || error_o !== m_err) begin
                tests_failed++;
                $display("FAIL rand_regs cycle=%0d got v=%b f=%h c=%b n=%0d e=%b want v=%b f=%h c=%b n=%0d e=%b",
                         c, is_valid_o, flit_o, credit_o, flit_count_o, error_o,
                         m_valid, m_flit, m_credit, m_count, m_err);
            end
            $display("[TB] rand cycle=%0d req=%b grant=%b valid_in=%b credit=%b count=%0d", c, r_la_i, g_la_o, is_valid_i, credit_o, flit_count_o);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        test_reset();
        test_round_robin();
        test_latency();
        test_credit();
        test_collision();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
